// File: rtl/dp_sync_ram_if.sv
// Purpose: bundles both RAM ports (enable, write enable, address, write data, read data).
// Latency: none, wiring only.
// Backpressure: none; every enabled edge is accepted by the RAM.
interface dp_sync_ram_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
);
  logic              en_a;
  logic              wren_a;
  logic [ADDR_W-1:0] addr_a;
  logic [WIDTH-1:0]  data_a;
  logic [WIDTH-1:0]  q_a;

  logic              en_b;
  logic              wren_b;
  logic [ADDR_W-1:0] addr_b;
  logic [WIDTH-1:0]  data_b;
  logic [WIDTH-1:0]  q_b;

  // Requester side: drives commands, receives read data.
  modport master (
    output en_a, wren_a, addr_a, data_a,
    output en_b, wren_b, addr_b, data_b,
    input  q_a, q_b
  );

  // RAM side: receives commands, returns read data.
  modport slave (
    input  en_a, wren_a, addr_a, data_a,
    input  en_b, wren_b, addr_b, data_b,
    output q_a, q_b
  );
endinterface

// File: rtl/dp_sync_ram.sv
// Purpose: true dual-port synchronous RAM (default 64 x 32) backing the GPU register bank.
// Latency: 1 cycle read; writes visible to reads sampled on the following edge.
// Backpressure: none; enabled edges always accepted. Macro DPRAM_NEW_DATA_EN selects
// new-data same-port read-during-write (default: old data).
module dp_sync_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  dp_sync_ram_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  // Storage powers up as zero and is deliberately left untouched by reset.
  logic [WIDTH-1:0] r_mem [0:DEPTH-1] = '{default: '0};

  logic [WIDTH-1:0] r_q_a;
  logic [WIDTH-1:0] r_q_b;

  logic             w_wr_a;
  logic             w_wr_b;
  logic             w_collide;
  logic             w_commit_a;
  logic [WIDTH-1:0] w_old_a;
  logic [WIDTH-1:0] w_old_b;
  logic [WIDTH-1:0] w_next_a;
  logic [WIDTH-1:0] w_next_b;

  assign w_wr_a     = bus.en_a & bus.wren_a;
  assign w_wr_b     = bus.en_b & bus.wren_b;
  // Both ports writing the same word: port B's data is the one kept.
  assign w_collide  = w_wr_a & w_wr_b & (bus.addr_a == bus.addr_b);
  assign w_commit_a = w_wr_a & ~w_collide;

  // Array contents before this edge's writes, so mixed-port reads see old data.
  assign w_old_a = r_mem[bus.addr_a];
  assign w_old_b = r_mem[bus.addr_b];

`ifdef DPRAM_NEW_DATA_EN
  // A writing port returns its own write data, even when it lost a collision.
  assign w_next_a = w_wr_a ? bus.data_a : w_old_a;
  assign w_next_b = w_wr_b ? bus.data_b : w_old_b;
`else
  // A writing port returns the word as it was before the write.
  assign w_next_a = w_old_a;
  assign w_next_b = w_old_b;
`endif

  // Commit writes; suppressed while reset is held.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      if (w_commit_a) r_mem[bus.addr_a] <= bus.data_a;
      if (w_wr_b)     r_mem[bus.addr_b] <= bus.data_b;
    end
  end

  // Port A read register: cleared by reset, holds while the port is disabled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    r_q_a <= '0;
    else if (bus.en_a) r_q_a <= w_next_a;
  end

  // Port B read register: cleared by reset, holds while the port is disabled.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    r_q_b <= '0;
    else if (bus.en_b) r_q_b <= w_next_b;
  end

  assign bus.q_a = r_q_a;
  assign bus.q_b = r_q_b;
endmodule

// File: tb/tb_dp_sync_ram.sv
// Purpose: self-checking bench for dp_sync_ram with a behavioural array model.
// Latency: checks read data one edge after each enabled read.
// Backpressure: none exercised; the RAM never stalls.
module tb_dp_sync_ram;
`ifdef DPRAM_NEW_DATA_EN
  localparam bit NEW_DATA = 1'b1;
`else
  localparam bit NEW_DATA = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dp_sync_ram_if #(.WIDTH(32), .ADDR_W(6)) bus ();

  dp_sync_ram #(.WIDTH(32), .ADDR_W(6)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  // Behavioural model: reads take the array as it stood before the edge,
  // then writes apply in port order so port B's write lands last.
  logic [31:0] m_mem [64];
  logic [31:0] m_q_a = '0;
  logic [31:0] m_q_b = '0;

  initial for (int i = 0; i < 64; i++) m_mem[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] old_a, old_b;
    if (!rst_n) begin
      m_q_a = '0;
      m_q_b = '0;
    end else begin
      old_a = m_mem[bus.addr_a];
      old_b = m_mem[bus.addr_b];
      if (bus.en_a) m_q_a = (NEW_DATA && bus.wren_a) ? bus.data_a : old_a;
      if (bus.en_b) m_q_b = (NEW_DATA && bus.wren_b) ? bus.data_b : old_b;
      if (bus.en_a && bus.wren_a) m_mem[bus.addr_a] = bus.data_a;
      if (bus.en_b && bus.wren_b) m_mem[bus.addr_b] = bus.data_b;
    end
  end

  // Every cycle: DUT outputs against the model, away from the rising edge.
  always @(negedge clk) begin
    tests++;
    if (bus.q_a !== m_q_a) begin
      fails++;
      $display("FAIL cycle_q_a t=%0t got=%h want=%h", $time, bus.q_a, m_q_a);
    end
    tests++;
    if (bus.q_b !== m_q_b) begin
      fails++;
      $display("FAIL cycle_q_b t=%0t got=%h want=%h", $time, bus.q_b, m_q_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Apply one set of port inputs, take one rising edge, settle 2 time units.
  task automatic step(input logic ea, input logic wa, input logic [5:0] aa, input logic [31:0] da,
                      input logic eb, input logic wb, input logic [5:0] ab, input logic [31:0] db);
    bus.en_a   = ea;
    bus.wren_a = wa;
    bus.addr_a = aa;
    bus.data_a = da;
    bus.en_b   = eb;
    bus.wren_b = wb;
    bus.addr_b = ab;
    bus.data_b = db;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    idle();
    idle();
    rst_n = 1'b1;
    chk("reset_q_a", bus.q_a, 32'h0);
    chk("reset_q_b", bus.q_b, 32'h0);

    // Load 0x1234 into both read registers, then reset mid-cycle.
    step(1'b1, 1'b1, 6'd1, 32'h1234, 1'b0, 1'b0, 6'd0, 32'h0);
    step(1'b1, 1'b0, 6'd1, 32'h0, 1'b1, 1'b0, 6'd1, 32'h0);
    chk("pre_rst_q_a", bus.q_a, 32'h1234);
    chk("pre_rst_q_b", bus.q_b, 32'h1234);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_q_a", bus.q_a, 32'h0);
    chk("async_rst_q_b", bus.q_b, 32'h0);
    step(1'b1, 1'b1, 6'd3, 32'hDEAD, 1'b0, 1'b0, 6'd0, 32'h0);
    step(1'b1, 1'b1, 6'd3, 32'hDEAD, 1'b0, 1'b0, 6'd0, 32'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 6'd3, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    chk("rst_write_suppressed", bus.q_a, 32'h0);

    // Basic write on A, read back on B.
    step(1'b1, 1'b1, 6'd5, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0, 32'h0);
    step(1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 6'd5, 32'h0);
    chk("basic_q_b", bus.q_b, 32'hA5A5A5A5);

    // Read-during-write on addr 7.
    step(1'b1, 1'b1, 6'd7, 32'h11111111, 1'b0, 1'b0, 6'd0, 32'h0);
    step(1'b1, 1'b1, 6'd7, 32'h22222222, 1'b1, 1'b0, 6'd7, 32'h0);
    chk("rdw_same_q_a", bus.q_a, NEW_DATA ? 32'h22222222 : 32'h11111111);
    chk("rdw_mixed_q_b", bus.q_b, 32'h11111111);
    chk("model_rdw_q_b", m_q_b, 32'h11111111);
    step(1'b1, 1'b0, 6'd7, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    chk("rdw_after_q_a", bus.q_a, 32'h22222222);

    // Collision on addr 63: port B wins.
    step(1'b1, 1'b1, 6'd63, 32'hAAAAAAAA, 1'b1, 1'b1, 6'd63, 32'hBBBBBBBB);
    chk("coll_q_a", bus.q_a, NEW_DATA ? 32'hAAAAAAAA : 32'h0);
    chk("coll_q_b", bus.q_b, NEW_DATA ? 32'hBBBBBBBB : 32'h0);
    step(1'b1, 1'b0, 6'd63, 32'h0, 1'b1, 1'b0, 6'd63, 32'h0);
    chk("coll_rd_q_a", bus.q_a, 32'hBBBBBBBB);
    chk("coll_rd_q_b", bus.q_b, 32'hBBBBBBBB);
    chk("model_coll", m_mem[63], 32'hBBBBBBBB);

    // Simultaneous writes to different addresses both land.
    step(1'b1, 1'b1, 6'd10, 32'h10101010, 1'b1, 1'b1, 6'd11, 32'h11111100);
    step(1'b1, 1'b0, 6'd11, 32'h0, 1'b1, 1'b0, 6'd10, 32'h0);
    chk("dual_q_a", bus.q_a, 32'h11111100);
    chk("dual_q_b", bus.q_b, 32'h10101010);

    // Enable hold: disabled port ignores wren and keeps its output.
    step(1'b1, 1'b1, 6'd9, 32'hCAFEF00D, 1'b0, 1'b0, 6'd0, 32'h0);
    step(1'b1, 1'b0, 6'd9, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    chk("hold_load_q_a", bus.q_a, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 6'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 6'd0, 32'h0);
      chk("hold_q_a", bus.q_a, 32'hCAFEF00D);
    end
    step(1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 6'd0, 32'h0);
    chk("hold_mem0", bus.q_b, 32'h0);

    // Sweep: write every word on A, read every word on B.
    for (int i = 0; i < 64; i++)
      step(1'b1, 1'b1, 6'(i), 32'(i) ^ 32'h5A5A5A5A, 1'b0, 1'b0, 6'd0, 32'h0);
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 6'(i), 32'h0);
      chk("sweep_q_b", bus.q_b, 32'(i) ^ 32'h5A5A5A5A);
    end
    chk("sweep_first", m_mem[0], 32'h5A5A5A5A);
    chk("sweep_last", m_mem[63], 32'h5A5A5A65);

    idle();
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
